mux_n_1_arb: RTL and testbench

- Parametrised successor to the datapath's 2:1 select mux: N-channel, WIDTH-bit, registered stream multiplexer with valid/ready handshakes.
- Two select modes: fixed (external sel, as in the multicycle control path) and round-robin arbitration.
- Sits between multiple producers (ALU result, memory read data, immediate/PC sources) and a single registered consumer port. Provides one-cycle latency and back-pressure.

---
 rtl/mux_n_1_arb.sv | 68 ++++++
 tb/tb_mux_n_1_arb.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mux_n_1_arb.sv
// mux_n_1_arb: N-channel registered stream mux with valid/ready handshakes,
// offering a fixed select mode and a round-robin arbitration mode.
module mux_n_1_arb #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode_i,
  input  logic [SEL_W-1:0]   sel_i,
  input  logic [N*WIDTH-1:0] in_data_i,
  input  logic [N-1:0]       in_valid_i,
  output logic [N-1:0]       in_ready_o,
  output logic [WIDTH-1:0]   out_data_o,
  output logic [SEL_W-1:0]   out_src_o,
  output logic               out_valid_o,
  input  logic               out_ready_i
);
  localparam int NP = 2 ** SEL_W;
  typedef enum logic {EMPTY, FULL} state_t;
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SEL_W-1:0]   src_q, src_d, rr_q, rr_d, rr_g, idx, g;
  logic [NP-1:0]      v_pad;
  logic               can_accept, rr_hit, fx_hit, hit;
  // Padding lets an out-of-range sel index safely; the range test rejects it.
  assign v_pad      = NP'(in_valid_i);
  assign can_accept = rst_n & ((state_q == EMPTY) | (out_ready_i & out_valid_o));
  always_comb begin
    rr_hit = 1'b0;
    rr_g   = '0;
    idx    = '0;
    for (int k = N; k >= 1; k--) begin
      idx = SEL_W'((int'(rr_q) + k) % N);
      if (v_pad[idx]) begin
        rr_hit = 1'b1;
        rr_g   = idx;
      end
    end
  end
  assign fx_hit     = (int'(sel_i) < N) & v_pad[sel_i];
  assign hit        = can_accept & (mode_i ? rr_hit : fx_hit);
  assign g          = mode_i ? rr_g : sel_i;
  assign in_ready_o = hit ? N'(1) << g : '0;
  always_comb begin
    state_d = hit ? FULL : (out_ready_i & out_valid_o) ? EMPTY : state_q;
    data_d  = hit ? in_data_i[int'(g)*WIDTH +: WIDTH] : data_q;
    src_d   = hit ? g : src_q;
    rr_d    = (hit & mode_i) ? g : rr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      src_q   <= '0;
      rr_q    <= SEL_W'(N - 1);
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      rr_q    <= rr_d;
    end
  end
  assign out_valid_o = (state_q == FULL);
  assign out_data_o  = data_q;
  assign out_src_o   = src_q;
endmodule

// File: tb/tb_mux_n_1_arb.sv
// tb_mux_n_1_arb: directed and randomized checks of mux_n_1_arb against a
// transaction-level model of the output register and round-robin pointer.
module tb_mux_n_1_arb;
  logic         clk = 1'b0, rst_n = 1'b0;
  logic         mode = 1'b0, out_ready = 1'b0, out_valid;
  logic [1:0]   sel = '0, out_src;
  logic [127:0] in_data = '0;
  logic [3:0]   in_valid = '0, in_ready;
  logic [31:0]  out_data;
  logic [2:0]   sel6 = '0, out_src6;
  logic [191:0] data6 = '0;
  logic [5:0]   valid6 = '0, ready6;
  logic [31:0]  out_data6;
  logic         out_valid6;
  int n_chk = 0, n_pass = 0;
  bit m_full;
  logic [31:0] m_data, saved;
  int m_src, m_ptr;

  mux_n_1_arb #(.WIDTH(32), .N(4), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .mode_i(mode), .sel_i(sel), .in_data_i(in_data),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .out_data_o(out_data),
    .out_src_o(out_src), .out_valid_o(out_valid), .out_ready_i(out_ready));

  mux_n_1_arb #(.WIDTH(32), .N(6), .SEL_W(3)) u6 (
    .clk(clk), .rst_n(rst_n), .mode_i(1'b0), .sel_i(sel6), .in_data_i(data6),
    .in_valid_i(valid6), .in_ready_o(ready6), .out_data_o(out_data6),
    .out_src_o(out_src6), .out_valid_o(out_valid6), .out_ready_i(1'b1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Which channel the spec's grant rule picks this cycle, or -1 for none.
  function automatic int mgrant();
    if (m_full && !out_ready) return -1;
    if (!mode) return in_valid[sel] ? int'(sel) : -1;
    for (int k = 1; k <= 4; k++)
      if (in_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_full = 0; m_data = '0; m_src = 0; m_ptr = 3;
  endtask

  task automatic rand_data();
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = $urandom;
  endtask

  // One cycle: apply inputs at the falling edge, check ready, then outputs.
  task automatic step(input logic m, input logic [1:0] s, input logic [3:0] v, input logic r);
    int gnt;
    logic [3:0] exp_rdy;
    mode = m; sel = s; in_valid = v; out_ready = r;
    #1;
    gnt = mgrant();
    exp_rdy = (gnt < 0) ? 4'b0 : 4'(1 << gnt);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (gnt >= 0) begin
      m_full = 1; m_data = in_data[gnt*32 +: 32]; m_src = gnt;
      if (m) m_ptr = gnt;
    end else if (r) m_full = 0;
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(m_full));
    chk("out_data", out_data, m_data);
    chk("out_src", 32'(out_src), 32'(m_src));
  endtask

  task automatic do_reset();
    rst_n = 0; in_valid = '0;
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(in_ready), 0);
    rst_n = 1;
    step(0, 2'd0, 4'b0000, 1);
    // Fixed select, then a back-to-back stream.
    in_data = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
    step(0, 2'd2, 4'b1111, 1);
    chk("fix_data", out_data, 32'hA5A5_0002);
    chk("fix_src", 32'(out_src), 2);
    for (int i = 0; i < 4; i++) begin
      rand_data();
      step(0, 2'd2, 4'b1111, 1);
      chk("stream_valid", 32'(out_valid), 1);
    end
    // Asynchronous reset between clock edges while holding a word.
    #3 rst_n = 0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_data", out_data, 0);
    chk("arst_src", 32'(out_src), 0);
    chk("arst_ready", 32'(in_ready), 0);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    step(0, 2'd0, 4'b0000, 0);
    // Round-robin fairness over channels 0, 1 and 3.
    for (int i = 0; i < 6; i++) begin
      rand_data();
      step(1, 2'd0, 4'b1011, 1);
      chk("rr_src", 32'(out_src), (i % 3 == 2) ? 3 : i % 3);
    end
    // Back-pressure while inputs toggle, then drain and load on one edge.
    saved = out_data;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      step(1, 2'($urandom), 4'($urandom), 0);
      chk("bp_data", out_data, saved);
      chk("bp_src", 32'(out_src), 3);
    end
    rand_data();
    step(1, 2'd0, 4'b1111, 1);
    chk("bp_reload_src", 32'(out_src), 0);
    saved = out_data;
    step(1, 2'd0, 4'b0000, 1);
    chk("drain_valid", 32'(out_valid), 0);
    chk("drain_hold", out_data, saved);
    // Mode switch keeps the round-robin pointer.
    do_reset();
    step(1, 2'd0, 4'b1111, 1);
    chk("sw_src0", 32'(out_src), 0);
    step(1, 2'd0, 4'b1111, 1);
    chk("sw_src1", 32'(out_src), 1);
    step(0, 2'd3, 4'b1111, 1);
    chk("sw_fixed", 32'(out_src), 3);
    step(1, 2'd0, 4'b1111, 1);
    chk("sw_rr_next", 32'(out_src), 2);
    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      rand_data();
      step(1'($urandom), 2'($urandom), 4'($urandom), $urandom_range(0, 3) != 0);
    end
    // Out-of-range select on a six-channel build.
    in_valid = '0;
    for (int i = 0; i < 6; i++) data6[i*32 +: 32] = 32'hC0DE_0000 + i;
    valid6 = 6'b111111;
    for (int s = 6; s <= 7; s++) begin
      sel6 = 3'(s);
      #1 chk("sel_oob_ready", 32'(ready6), 0);
      @(negedge clk);
      chk("sel_oob_valid", 32'(out_valid6), 0);
    end
    sel6 = 3'd5;
    #1 chk("sel5_ready", 32'(ready6), 32'b100000);
    @(negedge clk);
    chk("sel5_valid", 32'(out_valid6), 1);
    chk("sel5_src", 32'(out_src6), 5);
    chk("sel5_data", out_data6, 32'hC0DE_0005);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
